// File: rtl/gate4_sweep_ctrl_v.sv
`default_nettype none
// ============================================================================
// Module   : gate4_sweep_ctrl_v
// Purpose  : Exhaustive 16-vector sweep of a 4-input gate with mismatch count.
// Revision : 1.0 - initial release
// ============================================================================
module gate4_sweep_ctrl_v #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [1:0] i_func,
    input  logic       i_f,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [4:0] o_err_cnt,
    output logic       o_first_err_vld,
    output logic [3:0] o_first_err_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] vec_q;
    logic [3:0] settle_q;
    logic [1:0] func_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [4:0] err_cnt_q;
    logic [4:0] err_cnt_d;
    logic       first_vld_q;
    logic [3:0] first_vec_q;
    logic       exp_f;
    logic       sample;
    logic       mismatch;

    always_comb begin
        exp_f = 1'b0;
        case (func_q)
            2'b00:   exp_f = ~(&vec_q);
            2'b01:   exp_f = &vec_q;
            2'b10:   exp_f = ~(|vec_q);
            default: exp_f = |vec_q;
        endcase
        sample    = (state_q == S_DRIVE) && (settle_q == SETTLE_LAST);
        mismatch  = sample && (i_f != exp_f);
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != 5'd16)) begin
            err_cnt_d = err_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 4'd0;
            settle_q    <= 4'd0;
            func_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 5'd0;
            first_vld_q <= 1'b0;
            first_vec_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Abort has priority over a simultaneous start request.
                    if (i_start && !i_abort) begin
                        func_q      <= i_func;
                        err_cnt_q   <= 5'd0;
                        first_vld_q <= 1'b0;
                        first_vec_q <= 4'd0;
                        pass_q      <= 1'b0;
                        vec_q       <= 4'd0;
                        settle_q    <= 4'd0;
                        busy_q      <= 1'b1;
                        state_q     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (i_abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        vec_q    <= 4'd0;
                        settle_q <= 4'd0;
                        pass_q   <= 1'b0;
                    end else begin
                        err_cnt_q <= err_cnt_d;
                        if (mismatch && !first_vld_q) begin
                            first_vld_q <= 1'b1;
                            first_vec_q <= vec_q;
                        end
                        if (sample) begin
                            settle_q <= 4'd0;
                            if (vec_q == 4'hF) begin
                                // Verdict includes the vector-15 result sampled on this edge.
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (err_cnt_d == 5'd0);
                                vec_q   <= 4'd0;
                            end else begin
                                vec_q <= vec_q + 4'd1;
                            end
                        end else begin
                            settle_q <= settle_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a             = vec_q[3];
    assign o_b             = vec_q[2];
    assign o_c             = vec_q[1];
    assign o_d             = vec_q[0];
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_pass          = pass_q;
    assign o_err_cnt       = err_cnt_q;
    assign o_first_err_vld = first_vld_q;
    assign o_first_err_vec = first_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate4_sweep_ctrl_v.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate4_sweep_ctrl_v
// Purpose  : Directed self-checking bench for gate4_sweep_ctrl_v.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate4_sweep_ctrl_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, abort0, f0;
    logic [1:0] func0;
    logic       a0, b0, c0, d0, busy0, done0, pass0, fv0;
    logic [4:0] err0;
    logic [3:0] fvec0;
    logic       start1, abort1, f1;
    logic [1:0] func1;
    logic       a1, b1, c1, d1, busy1, done1, pass1, fv1;
    logic [4:0] err1;
    logic [3:0] fvec1;

    int         mode0, mode1;
    logic [1:0] mfunc0, mfunc1;
    int         checks = 0;
    int         errors = 0;

    gate4_sweep_ctrl_v #(.SETTLE_CYCLES(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_abort(abort0),
        .i_func(func0), .i_f(f0), .o_a(a0), .o_b(b0), .o_c(c0), .o_d(d0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0),
        .o_first_err_vld(fv0), .o_first_err_vec(fvec0)
    );

    gate4_sweep_ctrl_v #(.SETTLE_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort1),
        .i_func(func1), .i_f(f1), .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
        .o_first_err_vld(fv1), .o_first_err_vec(fvec1)
    );

    // Gate under test: mode 0 = healthy gate of type fn, 1 = stuck at 1, 2 = stuck at 0.
    function automatic logic gate(input int mode, input logic [1:0] fn, input logic [3:0] v);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        case (fn)
            2'b00:   return ~(&v);
            2'b01:   return &v;
            2'b10:   return ~(|v);
            default: return |v;
        endcase
    endfunction

    assign f0 = gate(mode0, mfunc0, {a0, b0, c0, d0});
    assign f1 = gate(mode1, mfunc1, {a1, b1, c1, d1});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep on the SETTLE=2 instance, checks the vector walk, returns the done cycle.
    task automatic run_sweep0(input logic [1:0] fn, output int done_at);
        logic [3:0] ev;
        done_at = -1;
        func0  = fn;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done0) begin
                done_at = k;
                checks++;
                if (busy0 !== 1'b0) begin
                    errors++;
                    $display("FAIL done_busy: got %b want 0", busy0);
                end
                break;
            end
            if (k <= 32) begin
                ev = 4'((k - 1) / 2);
                checks++;
                if ({a0, b0, c0, d0} !== ev || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL vec_walk k=%0d: got vec=%h busy=%b want vec=%h busy=1",
                             k, {a0, b0, c0, d0}, busy0, ev);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, err0, fv0, fvec0} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {a0, b0, c0, d0, busy0, done0, pass0, err0, fv0, fvec0});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nand_good;
        int d;
        mode0 = 0; mfunc0 = 2'b00;
        run_sweep0(2'b00, d);
        checks++;
        if (d !== 33) begin errors++; $display("FAIL nand_good_latency: got %0d want 33", d); end
        checks++;
        if ({pass0, err0, fv0} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL nand_good_result: got pass=%b err=%0d fv=%b want 1 0 0", pass0, err0, fv0);
        end
        tick();
        checks++;
        if ({done0, busy0, pass0, a0, b0, c0, d0} !== 7'b0010000) begin
            errors++;
            $display("FAIL idle_hold: got done=%b busy=%b pass=%b vec=%h want 0 0 1 0",
                     done0, busy0, pass0, {a0, b0, c0, d0});
        end
    endtask

    task automatic test_nand_stuck1;
        int d;
        mode0 = 1;
        run_sweep0(2'b00, d);
        checks++;
        if (d !== 33) begin errors++; $display("FAIL stuck1_latency: got %0d want 33", d); end
        checks++;
        if ({pass0, err0, fv0, fvec0} !== {1'b0, 5'd1, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL stuck1_result: got pass=%b err=%0d fv=%b fvec=%h want 0 1 1 f",
                     pass0, err0, fv0, fvec0);
        end
        tick();
    endtask

    task automatic test_or_stuck0;
        int d;
        mode0 = 2;
        run_sweep0(2'b11, d);
        checks++;
        if (d !== 33) begin errors++; $display("FAIL or_stuck0_latency: got %0d want 33", d); end
        checks++;
        if ({pass0, err0, fv0, fvec0} !== {1'b0, 5'd15, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL or_stuck0_result: got pass=%b err=%0d fv=%b fvec=%h want 0 15 1 1",
                     pass0, err0, fv0, fvec0);
        end
        tick();
    endtask

    task automatic test_abort;
        int bad;
        mode0 = 2;
        func0 = 2'b00;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k < 15; k++) begin
            start0 = (k == 5);
            tick();
        end
        start0 = 1'b0;
        checks++;
        if ({a0, b0, c0, d0} !== 4'h7) begin
            errors++;
            $display("FAIL abort_vec7: got %h want 7", {a0, b0, c0, d0});
        end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        checks++;
        if ({busy0, done0, pass0, a0, b0, c0, d0} !== 7'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b pass=%b vec=%h want 0 0 0 0",
                     busy0, done0, pass0, {a0, b0, c0, d0});
        end
        checks++;
        if ({err0, fv0, fvec0} !== {5'd7, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL abort_partial: got err=%0d fv=%b fvec=%h want 7 1 0", err0, fv0, fvec0);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (done0 || busy0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d busy/done cycles want 0", bad); end
    endtask

    task automatic test_abort_start_idle;
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        tick();
        checks++;
        if ({busy0, done0, err0} !== {1'b0, 1'b0, 5'd7}) begin
            errors++;
            $display("FAIL abort_wins: got busy=%b done=%b err=%0d want 0 0 7", busy0, done0, err0);
        end
    endtask

    task automatic test_reset_mid;
        int d;
        mode0 = 2;
        func0 = 2'b11;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k < 19; k++) tick();
        checks++;
        if ({a0, b0, c0, d0, busy0} !== 5'b10011 || err0 === 5'd0) begin
            errors++;
            $display("FAIL pre_reset: got vec=%h busy=%b err=%0d want 9 1 nonzero",
                     {a0, b0, c0, d0}, busy0, err0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, err0, fv0, fvec0} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0",
                     {a0, b0, c0, d0, busy0, done0, pass0, err0, fv0, fvec0});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({busy0, done0} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b want 0 0", busy0, done0);
        end
        mode0 = 0; mfunc0 = 2'b00;
        run_sweep0(2'b00, d);
        checks++;
        if (d !== 33 || pass0 !== 1'b1 || err0 !== 5'd0) begin
            errors++;
            $display("FAIL resume_sweep: got done_at=%0d pass=%b err=%0d want 33 1 0", d, pass0, err0);
        end
        tick();
    endtask

    task automatic test_settle1_func_toggle;
        int d;
        logic [3:0] ev;
        d = -1;
        mode1 = 0; mfunc1 = 2'b01;
        func1 = 2'b01;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 8) func1 = 2'b10;
            if (done1) begin
                d = k;
                break;
            end
            if (k <= 16) begin
                ev = 4'(k - 1);
                checks++;
                if ({a1, b1, c1, d1} !== ev) begin
                    errors++;
                    $display("FAIL s1_vec k=%0d: got %h want %h", k, {a1, b1, c1, d1}, ev);
                end
            end
            tick();
        end
        checks++;
        if (d !== 17) begin errors++; $display("FAIL s1_latency: got %0d want 17", d); end
        checks++;
        if ({pass1, err1, fv1} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL s1_result: got pass=%b err=%0d fv=%b want 1 0 0", pass1, err1, fv1);
        end
    endtask

    initial begin
        start0 = 1'b0; abort0 = 1'b0; func0 = 2'b00;
        start1 = 1'b0; abort1 = 1'b0; func1 = 2'b00;
        mode0 = 0; mode1 = 0; mfunc0 = 2'b00; mfunc1 = 2'b00;
        test_reset();
        test_nand_good();
        test_nand_stuck1();
        test_or_stuck0();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
        test_settle1_func_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
